vga_sync_receiver: RTL and testbench

- Receive end of the VGA link driven by the game's VGA output stage: consumes HS, VS and the 8-bit colour bus.
- Recovers pixel coordinates, checks the 640x480@60 timing, and emits one strobe per visible pixel with its sampled colour.
- Sits in the self-check/capture path beside the game top: frame checker on the board, golden monitor in simulation.

---
 rtl/vga_sync_receiver_if.sv | 21 ++
 rtl/vga_sync_receiver.sv | 129 ++++++++++++
 tb/tb_vga_sync_receiver.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_receiver_if.sv
// vga_sync_receiver_if: VGA pins into the receiver and recovered pixel/status outputs.
interface vga_sync_receiver_if;
   logic       HS;
   logic       VS;
   logic [7:0] COLOUR_IN;
   logic [9:0] X;
   logic [8:0] Y;
   logic [7:0] COLOUR_OUT;
   logic       PIX_VALID;
   logic       FRAME_START;
   logic       LOCKED;
   logic       ERROR;
   modport master (
      output HS, VS, COLOUR_IN,
      input  X, Y, COLOUR_OUT, PIX_VALID, FRAME_START, LOCKED, ERROR
   );
   modport slave (
      input  HS, VS, COLOUR_IN,
      output X, Y, COLOUR_OUT, PIX_VALID, FRAME_START, LOCKED, ERROR
   );
endinterface

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers VGA pixel coordinates, checks line/frame timing and
// strobes each visible pixel with its mid-pixel colour sample once timing is locked.
module vga_sync_receiver #(
   parameter int PIX_DIV   = 4,
   parameter int H_VISIBLE = 640,
   parameter int H_BACK    = 48,
   parameter int H_SYNC    = 96,
   parameter int H_TOTAL   = 800,
   parameter int V_VISIBLE = 480,
   parameter int V_BACK    = 33,
   parameter int V_SYNC    = 2,
   parameter int V_TOTAL   = 525,
   parameter int TOL       = 2
) (
   input  logic               CLOCK,
   input  logic               RESET,
   vga_sync_receiver_if.slave bus
);
   localparam logic [11:0] LP_LO    = 12'(H_TOTAL * PIX_DIV - TOL);
   localparam logic [11:0] LP_HI    = 12'(H_TOTAL * PIX_DIV + TOL);
   localparam logic [11:0] LP_MISS  = 12'(H_TOTAL * PIX_DIV + TOL + 1);
   localparam logic [7:0]  SUB_LAST = 8'(PIX_DIV - 1);
   localparam logic [7:0]  SUB_MID  = 8'(PIX_DIV / 2);
   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  H_OFF    = 10'(H_SYNC + H_BACK);
   localparam logic [9:0]  H_END    = 10'(H_SYNC + H_BACK + H_VISIBLE);
   localparam logic [9:0]  V_OFF    = 10'(V_SYNC + V_BACK);
   localparam logic [9:0]  V_END    = 10'(V_SYNC + V_BACK + V_VISIBLE);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);

   typedef enum logic [1:0] {S_SEARCH, S_ACQ, S_LOCK} state_t;

   state_t      r_state, w_next;
   logic        r_hs1, r_hs2, r_hs3, r_vs1, r_vs2, r_vs3;
   logic [7:0]  r_c1, r_c2, r_c3;
   logic [11:0] r_lcnt;
   logic [7:0]  r_sub;
   logic [9:0]  r_h, r_line;
   logic        r_first, r_pv, r_fs, r_err;
   logic [9:0]  r_x;
   logic [8:0]  r_y;
   logic [7:0]  r_col;
   logic        w_hs_fall, w_vs_fall, w_sub_wrap, w_line_bad, w_miss, w_frame_bad, w_viol;
   logic        w_active, w_pix;
   logic [9:0]  w_hv;
   logic [8:0]  w_lv;

   assign w_hs_fall   = r_hs3 & ~r_hs2;
   assign w_vs_fall   = r_vs3 & ~r_vs2;
   assign w_sub_wrap  = r_sub == SUB_LAST;
   assign w_line_bad  = w_hs_fall & ~r_first & (r_lcnt < LP_LO || r_lcnt > LP_HI);
   assign w_miss      = ~w_hs_fall & (r_lcnt == LP_MISS);
   assign w_frame_bad = w_vs_fall & (r_line != V_LAST);
   assign w_viol      = w_line_bad | w_miss | w_frame_bad;
   assign w_hv        = r_h - H_OFF;
   assign w_lv        = 9'(r_line - V_OFF);
   assign w_active    = r_h >= H_OFF && r_h < H_END && r_line >= V_OFF && r_line < V_END;
   // gating on the next state as well kills the strobe in the very cycle a violation is seen
   assign w_pix       = r_state == S_LOCK && w_next == S_LOCK && w_active && r_sub == SUB_MID;

   always_comb begin
      w_next = r_state;
      w_next = (r_state == S_SEARCH) ? (w_vs_fall ? S_ACQ : S_SEARCH) :
               w_viol ? S_SEARCH : w_vs_fall ? S_LOCK : r_state;
   end

   // sync flops idle high so a reset never fakes a falling edge by itself
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         {r_hs1, r_hs2, r_hs3} <= 3'b111;
         {r_vs1, r_vs2, r_vs3} <= 3'b111;
         r_c1 <= '0;
         r_c2 <= '0;
         r_c3 <= '0;
      end else begin
         {r_hs1, r_hs2, r_hs3} <= {bus.HS, r_hs1, r_hs2};
         {r_vs1, r_vs2, r_vs3} <= {bus.VS, r_vs1, r_vs2};
         r_c1 <= bus.COLOUR_IN;
         r_c2 <= r_c1;
         r_c3 <= r_c2;
      end
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_lcnt  <= '0;
         r_sub   <= '0;
         r_h     <= '0;
         r_line  <= '0;
         r_first <= 1'b0;
      end else begin
         r_lcnt  <= w_hs_fall ? '0 : (&r_lcnt ? r_lcnt : r_lcnt + 12'd1);
         r_sub   <= (w_hs_fall | w_sub_wrap) ? '0 : r_sub + 8'd1;
         r_h     <= w_hs_fall ? '0 : !w_sub_wrap ? r_h : (r_h == H_LAST ? '0 : r_h + 10'd1);
         r_line  <= w_vs_fall ? '0 : w_hs_fall ? r_line + 10'd1 : r_line;
         r_first <= (r_state == S_SEARCH && w_next == S_ACQ) ? 1'b1 : w_hs_fall ? 1'b0 : r_first;
      end
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_state <= S_SEARCH;
         r_pv    <= 1'b0;
         r_fs    <= 1'b0;
         r_err   <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
         r_col   <= '0;
      end else begin
         r_state <= w_next;
         r_pv    <= w_pix;
         r_fs    <= w_vs_fall && w_next == S_LOCK;
         r_err   <= w_viol && r_state != S_SEARCH;
         if (w_pix) begin
            r_x   <= w_hv;
            r_y   <= w_lv;
            r_col <= r_c3;
         end
      end
   end

   assign bus.X           = r_x;
   assign bus.Y           = r_y;
   assign bus.COLOUR_OUT  = r_col;
   assign bus.PIX_VALID   = r_pv;
   assign bus.FRAME_START = r_fs;
   assign bus.LOCKED      = r_state == S_LOCK;
   assign bus.ERROR       = r_err;
endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: drives scaled-down VGA frames and checks lock, errors and every
// pixel strobe against the pixels the source actually sent.
module tb_vga_sync_receiver;
   localparam int PD = 4, HV = 16, HB = 4, HSY = 6, HT = 30;
   localparam int VV = 8, VB = 3, VSY = 2, VT = 15, TOL = 2;
   localparam int NOM = HT * PD;
   localparam int NONE = 999;

   typedef struct {int x; int y; int c;} pix_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0, fails = 0;
   int   n_pv, n_fs, n_err, first_x, first_y, last_x, last_y;
   bit   seen_first;
   pix_t exq[$];

   always #5 clk = ~clk;

   vga_sync_receiver_if vif();

   vga_sync_receiver #(
      .PIX_DIV(PD), .H_VISIBLE(HV), .H_BACK(HB), .H_SYNC(HSY), .H_TOTAL(HT),
      .V_VISIBLE(VV), .V_BACK(VB), .V_SYNC(VSY), .V_TOTAL(VT), .TOL(TOL)
   ) dut (
      .CLOCK(clk),
      .RESET(rst_n),
      .bus(vif)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " X"}, 32'(vif.X), 0);
      chk({tag, " Y"}, 32'(vif.Y), 0);
      chk({tag, " COLOUR_OUT"}, 32'(vif.COLOUR_OUT), 0);
      chk({tag, " PIX_VALID"}, 32'(vif.PIX_VALID), 0);
      chk({tag, " FRAME_START"}, 32'(vif.FRAME_START), 0);
      chk({tag, " LOCKED"}, 32'(vif.LOCKED), 0);
      chk({tag, " ERROR"}, 32'(vif.ERROR), 0);
   endtask

   task automatic clr();
      n_pv = 0;
      n_fs = 0;
      n_err = 0;
      seen_first = 0;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (vif.FRAME_START === 1'b1) n_fs++;
         if (vif.ERROR === 1'b1) n_err++;
         if (vif.PIX_VALID === 1'b1) begin
            n_pv++;
            if (!seen_first) begin
               first_x = int'(vif.X);
               first_y = int'(vif.Y);
               seen_first = 1;
            end
            last_x = int'(vif.X);
            last_y = int'(vif.Y);
            chk("strobe expected", 32'(exq.size() != 0), 1);
            if (exq.size() != 0) begin
               pix_t p;
               p = exq.pop_front();
               chk("pix X", 32'(vif.X), p.x);
               chk("pix Y", 32'(vif.Y), p.y);
               chk("pix colour", 32'(vif.COLOUR_OUT), p.c);
            end
         end
      end
   end

   // One line of the source: HS low for the sync pixels, pixel h held for PD cycles.
   task automatic send_line(input int y, input int period, input bit hs_on, input bit push,
                            input int seed, input int rst_cyc, input bit rise);
      int h, hv;
      for (int c = 0; c < period; c++) begin
         @(posedge clk); #1;
         if (rise && c == 2) chk("locked before rise", 32'(vif.LOCKED), 0);
         if (rise && c == 3) begin
            chk("locked rise", 32'(vif.LOCKED), 1);
            chk("frame_start pulse", 32'(vif.FRAME_START), 1);
         end
         h  = c / PD;
         hv = h - HSY - HB;
         vif.HS = !(hs_on && c < HSY * PD);
         vif.VS = !(y < VSY);
         vif.COLOUR_IN = (hv >= 0 && hv < HV) ? 8'(hv ^ seed) : 8'($urandom);
         if (push && c % PD == 0 && hv >= 0 && hv < HV && y >= VSY + VB && y < VSY + VB + VV)
            exq.push_back('{hv, y - VSY - VB, (hv ^ seed) & 255});
         if (rst_cyc >= 0 && c == rst_cyc) begin
            rst_n = 1'b0;
            #1;
            chk_zero("async reset");
         end
         if (rst_cyc >= 0 && c == rst_cyc + 3) rst_n = 1'b1;
      end
   endtask

   // Strobes are expected for lines before the first disturbance; a long line still
   // delivers its own pixels, a missing HS or reset removes the line it hits.
   task automatic send_frame(input int nl, input bit exp_pix, input bit rise, input int seed,
                             input int long_ln, input int long_p, input int ok_ln, input int ok_p,
                             input int stop_ln, input int rst_ln);
      int cut, p;
      cut = long_ln + 1;
      if (stop_ln < cut) cut = stop_ln;
      if (rst_ln < cut) cut = rst_ln;
      for (int y = 0; y < nl; y++) begin
         p = (y == long_ln) ? long_p : (y == ok_ln) ? ok_p : NOM;
         send_line(y, p, y < stop_ln, exp_pix && y < cut, seed, (y == rst_ln) ? 30 : -1,
                   rise && y == 0);
      end
   endtask

   task automatic good(input bit exp_pix, input bit rise, input int seed);
      send_frame(VT, exp_pix, rise, seed, NONE, NOM, NONE, NOM, NONE, NONE);
   endtask

   initial begin
      vif.HS = 1'b1;
      vif.VS = 1'b1;
      vif.COLOUR_IN = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;
      repeat (10) @(posedge clk);

      // ideal source: lock at the 2nd VS fall, colour = X pattern
      clr();
      good(0, 0, 0);
      chk("A locked after 1st VS", 32'(vif.LOCKED), 0);
      good(1, 1, 0);
      chk("A locked after 2nd VS", 32'(vif.LOCKED), 1);
      good(1, 0, 0);
      chk("A locked frame 3", 32'(vif.LOCKED), 1);
      chk("A frame_start count", n_fs, 2);
      chk("A error count", n_err, 0);
      chk("A strobe count", n_pv, 2 * HV * VV);
      chk("A first X", first_x, 0);
      chk("A first Y", first_y, 0);
      chk("A last X", last_x, HV - 1);
      chk("A last Y", last_y, VV - 1);
      chk("A queue drained", exq.size(), 0);

      // line period jitter inside tolerance, then one line far too long
      clr();
      send_frame(VT, 1, 0, $urandom_range(0, 255), NONE, NOM, $urandom_range(1, VT - 2),
                 NOM + TOL, NONE, NONE);
      // count seen at the fall is period-1, so these periods land within NOM +/- TOL
      send_frame(VT, 1, 0, $urandom_range(0, 255), NONE, NOM, $urandom_range(1, VT - 2),
                 $urandom_range(NOM - TOL + 1, NOM + TOL + 1), NONE, NONE);
      chk("B locked with jitter", 32'(vif.LOCKED), 1);
      chk("B no error with jitter", n_err, 0);
      send_frame(VT, 1, 0, $urandom_range(0, 255), $urandom_range(1, VT - 3), NOM + 8,
                 NONE, NOM, NONE, NONE);
      chk("B unlocked after long line", 32'(vif.LOCKED), 0);
      chk("B single error", n_err, 1);
      chk("B strobes stopped", exq.size(), 0);
      good(0, 0, $urandom_range(0, 255));
      good(1, 1, $urandom_range(0, 255));
      chk("B relocked", 32'(vif.LOCKED), 1);
      chk("B error total", n_err, 1);
      chk("B frame_start count", n_fs, 4);

      // short frame: error at the closing VS fall, relock two good VS falls later
      clr();
      send_frame(VT - 1, 1, 0, $urandom_range(0, 255), NONE, NOM, NONE, NOM, NONE, NONE);
      chk("C locked before check", 32'(vif.LOCKED), 1);
      good(0, 0, $urandom_range(0, 255));
      chk("C unlocked", 32'(vif.LOCKED), 0);
      chk("C error", n_err, 1);
      good(0, 0, $urandom_range(0, 255));
      chk("C acquire only", 32'(vif.LOCKED), 0);
      good(1, 1, $urandom_range(0, 255));
      chk("C relocked", 32'(vif.LOCKED), 1);
      chk("C error total", n_err, 1);
      chk("C frame_start count", n_fs, 2);
      chk("C queue drained", exq.size(), 0);

      // HS stops while locked: one error only
      clr();
      send_frame(VT, 1, 0, $urandom_range(0, 255), NONE, NOM, NONE, NOM,
                 $urandom_range(1, VT - 1), NONE);
      chk("D unlocked", 32'(vif.LOCKED), 0);
      chk("D single error", n_err, 1);
      for (int i = 0; i < 40; i++) send_line(VSY, NOM, 0, 0, 0, -1, 0);
      chk("D no further error", n_err, 1);
      good(0, 0, $urandom_range(0, 255));
      good(1, 1, $urandom_range(0, 255));
      chk("D relocked", 32'(vif.LOCKED), 1);
      chk("D error total", n_err, 1);
      chk("D queue drained", exq.size(), 0);

      // reset mid-line while locked
      clr();
      send_frame(VT, 1, 0, $urandom_range(0, 255), NONE, NOM, NONE, NOM, NONE,
                 $urandom_range(VSY + VB + 1, VT - 2));
      chk("E unlocked after reset", 32'(vif.LOCKED), 0);
      good(0, 0, $urandom_range(0, 255));
      chk("E not locked at 1st VS", 32'(vif.LOCKED), 0);
      good(1, 1, $urandom_range(0, 255));
      chk("E locked at 2nd VS", 32'(vif.LOCKED), 1);
      chk("E no error", n_err, 0);
      chk("E frame_start count", n_fs, 2);
      chk("E queue drained", exq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
